// File: rtl/hemaia_mailbox_pkg.sv
// ============================================================================
// hemaia_mailbox_pkg: register map and STATUS layout shared by the mailbox.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package hemaia_mailbox_pkg;

    localparam int unsigned CHAN_STRIDE_WORDS = 8;
    localparam int unsigned CHAN_SHIFT        = $clog2(CHAN_STRIDE_WORDS);

    localparam logic [2:0] REG_WDATA   = 3'd0;
    localparam logic [2:0] REG_RDATA   = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_THRESH  = 3'd3;
    localparam logic [2:0] REG_IRQEN   = 3'd4;
    localparam logic [2:0] REG_IRQPEND = 3'd5;
    localparam logic [2:0] REG_FLUSH   = 3'd6;
    localparam logic [2:0] REG_RSVD    = 3'd7;

    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_USAGE_LSB = 2;

    // Direction legality of each register; everything else is a decode error.
    function automatic logic reg_access_legal(input logic [2:0] reg_idx, input logic we);
        logic ok;
        ok = 1'b0;
        case (reg_idx)
            REG_WDATA:   ok = we;
            REG_RDATA:   ok = !we;
            REG_STATUS:  ok = !we;
            REG_THRESH:  ok = 1'b1;
            REG_IRQEN:   ok = 1'b1;
            REG_IRQPEND: ok = 1'b1;
            REG_FLUSH:   ok = we;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hemaia_mbox_chan.sv
// ============================================================================
// hemaia_mbox_chan: one mailbox channel - FIFO, usage counter, irq logic.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hemaia_mbox_chan #(
    parameter int MailboxDepth = 8,
    parameter int DataWidth    = 32,
    parameter int IrqEdgeTrig  = 0,
    parameter int IrqActHigh   = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  logic [DataWidth-1:0]             push_data_i,
    input  logic                             pop_i,
    input  logic                             flush_i,
    input  logic                             thresh_we_i,
    input  logic                             irqen_we_i,
    input  logic                             pend_w1c_i,
    input  logic [$clog2(MailboxDepth):0]    wdata_i,
    output logic [DataWidth-1:0]             head_o,
    output logic [$clog2(MailboxDepth):0]    count_o,
    output logic                             empty_o,
    output logic                             full_o,
    output logic [$clog2(MailboxDepth):0]    thresh_o,
    output logic                             irqen_o,
    output logic                             irqpend_o,
    output logic                             irq_o
);

    localparam int U = $clog2(MailboxDepth);
    localparam logic IrqIdle = (IrqActHigh != 0) ? 1'b0 : 1'b1;

    logic [DataWidth-1:0] mem_q [MailboxDepth];
    logic [U-1:0]         wr_ptr_q, rd_ptr_q;
    logic [U:0]           count_q;
    logic [U:0]           thresh_q;
    logic                 irqen_q;
    logic                 pend_q;
    logic                 cond_q;
    logic                 irq_q;
    logic                 cond_d;
    logic                 irq_src_d;

    // Depth is a power of two, so the counter MSB alone marks "full".
    assign full_o    = count_q[U];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign thresh_o  = thresh_q;
    assign irqen_o   = irqen_q;
    assign irqpend_o = (IrqEdgeTrig != 0) ? pend_q : cond_d;
    assign irq_o     = irq_q;

    assign cond_d    = irqen_q & (count_q > thresh_q);
    assign irq_src_d = (IrqEdgeTrig != 0) ? (pend_q & irqen_q) : cond_d;

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            thresh_q <= '0;
            irqen_q  <= 1'b0;
            pend_q   <= 1'b0;
            cond_q   <= 1'b0;
            irq_q    <= IrqIdle;
        end else begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push_i, pop_i})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
            if (thresh_we_i) thresh_q <= wdata_i;
            if (irqen_we_i)  irqen_q  <= wdata_i[0];
            cond_q <= cond_d;
            // A rising condition beats a simultaneous W1C.
            if ((IrqEdgeTrig != 0) && cond_d && !cond_q) begin
                pend_q <= 1'b1;
            end else if (pend_w1c_i) begin
                pend_q <= 1'b0;
            end
            irq_q <= (IrqActHigh != 0) ? irq_src_d : ~irq_src_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hemaia_multi_mailbox.sv
// ============================================================================
// hemaia_multi_mailbox: multi-channel mailbox with bus decode and hw push lanes.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hemaia_multi_mailbox
    import hemaia_mailbox_pkg::*;
#(
    parameter int NumChannels  = 4,
    parameter int MailboxDepth = 8,
    parameter int DataWidth    = 32,
    parameter int AddrWidth    = 32,
    parameter int IrqEdgeTrig  = 0,
    parameter int IrqActHigh   = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    input  logic                             req_we_i,
    input  logic [AddrWidth-1:0]             req_addr_i,
    input  logic [DataWidth-1:0]             req_wdata_i,
    output logic                             req_ready_o,
    output logic                             rsp_valid_o,
    output logic [DataWidth-1:0]             rsp_rdata_o,
    output logic                             rsp_err_o,
    input  logic [AddrWidth-1:0]             base_addr_i,
    input  logic [NumChannels-1:0]           hw_push_valid_i,
    input  logic [NumChannels*DataWidth-1:0] hw_push_data_i,
    output logic [NumChannels-1:0]           hw_push_ready_o,
    output logic [NumChannels-1:0]           irq_o
);

    localparam int U         = $clog2(MailboxDepth);
    localparam int ByteShift = $clog2(DataWidth / 8);

    logic [AddrWidth-1:0] w_offset, w_word, w_chan_full;
    logic [2:0]           w_reg;
    logic                 w_below, w_chan_ok, w_dec_ok, w_hit, w_stall, w_accept;

    logic [NumChannels-1:0] w_sel, w_wdata_hit, w_flush_hit, w_hw_push;
    logic [NumChannels-1:0] w_full, w_empty, w_irqen, w_pend;
    logic [DataWidth-1:0]   w_head   [NumChannels];
    logic [U:0]             w_count  [NumChannels];
    logic [U:0]             w_thresh [NumChannels];

    logic                 w_s_full, w_s_empty, w_s_irqen, w_s_pend;
    logic [DataWidth-1:0] w_s_head, w_status;
    logic [U:0]           w_s_count, w_s_thresh;

    logic                 rsp_valid_q;
    logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    assign w_below     = (req_addr_i < base_addr_i);
    assign w_offset    = req_addr_i - base_addr_i;
    assign w_word      = w_offset >> ByteShift;
    assign w_reg       = w_word[CHAN_SHIFT-1:0];
    assign w_chan_full = w_word >> CHAN_SHIFT;
    assign w_chan_ok   = !w_below && (w_chan_full < AddrWidth'(NumChannels));
    assign w_dec_ok    = w_chan_ok && reg_access_legal(w_reg, req_we_i);
    assign w_hit       = req_valid_i && !rst_i && w_dec_ok;

    // Ready never depends on flush decode, so there is no ready/flush loop.
    assign w_stall     = |(w_wdata_hit & hw_push_valid_i & hw_push_ready_o);
    assign req_ready_o = !rst_i && !w_stall;
    assign w_accept    = req_valid_i && req_ready_o;

    generate
        for (genvar c = 0; c < NumChannels; c++) begin : g_chan
            logic w_push, w_pop, w_thresh_we, w_irqen_we, w_w1c;
            logic [DataWidth-1:0] w_push_data;

            assign w_sel[c]       = w_hit && (w_chan_full == AddrWidth'(c));
            assign w_wdata_hit[c] = w_sel[c] && req_we_i && (w_reg == REG_WDATA);
            assign w_flush_hit[c] = w_sel[c] && req_we_i && (w_reg == REG_FLUSH);

            assign hw_push_ready_o[c] = !rst_i && !w_full[c] && !w_flush_hit[c];
            assign w_hw_push[c]       = hw_push_valid_i[c] && hw_push_ready_o[c];

            assign w_push      = w_hw_push[c] || (w_accept && w_wdata_hit[c] && !w_full[c]);
            assign w_push_data = w_hw_push[c] ? hw_push_data_i[c*DataWidth +: DataWidth]
                                              : req_wdata_i;
            assign w_pop       = w_accept && w_sel[c] && !req_we_i && (w_reg == REG_RDATA)
                                 && !w_empty[c];
            assign w_thresh_we = w_accept && w_sel[c] && req_we_i && (w_reg == REG_THRESH);
            assign w_irqen_we  = w_accept && w_sel[c] && req_we_i && (w_reg == REG_IRQEN);
            assign w_w1c       = w_accept && w_sel[c] && req_we_i && (w_reg == REG_IRQPEND)
                                 && req_wdata_i[0];

            hemaia_mbox_chan #(
                .MailboxDepth (MailboxDepth),
                .DataWidth    (DataWidth),
                .IrqEdgeTrig  (IrqEdgeTrig),
                .IrqActHigh   (IrqActHigh)
            ) u_chan (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .push_i       (w_push),
                .push_data_i  (w_push_data),
                .pop_i        (w_pop),
                .flush_i      (w_accept && w_flush_hit[c]),
                .thresh_we_i  (w_thresh_we),
                .irqen_we_i   (w_irqen_we),
                .pend_w1c_i   (w_w1c),
                .wdata_i      (req_wdata_i[U:0]),
                .head_o       (w_head[c]),
                .count_o      (w_count[c]),
                .empty_o      (w_empty[c]),
                .full_o       (w_full[c]),
                .thresh_o     (w_thresh[c]),
                .irqen_o      (w_irqen[c]),
                .irqpend_o    (w_pend[c]),
                .irq_o        (irq_o[c])
            );
        end
    endgenerate

    always_comb begin
        w_s_full   = 1'b0;
        w_s_empty  = 1'b0;
        w_s_irqen  = 1'b0;
        w_s_pend   = 1'b0;
        w_s_head   = '0;
        w_s_count  = '0;
        w_s_thresh = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (w_chan_full == AddrWidth'(c)) begin
                w_s_full   = w_full[c];
                w_s_empty  = w_empty[c];
                w_s_irqen  = w_irqen[c];
                w_s_pend   = w_pend[c];
                w_s_head   = w_head[c];
                w_s_count  = w_count[c];
                w_s_thresh = w_thresh[c];
            end
        end
    end

    always_comb begin
        w_status = '0;
        w_status[STATUS_EMPTY_BIT]          = w_s_empty;
        w_status[STATUS_FULL_BIT]           = w_s_full;
        w_status[STATUS_USAGE_LSB +: U + 1] = w_s_count;
    end

    always_comb begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (!w_dec_ok) begin
            rsp_err_d = 1'b1;
        end else begin
            case (w_reg)
                REG_WDATA:   rsp_err_d = w_s_full;
                REG_RDATA: begin
                    if (w_s_empty) rsp_err_d   = 1'b1;
                    else           rsp_rdata_d = w_s_head;
                end
                REG_STATUS:  rsp_rdata_d = w_status;
                REG_THRESH:  if (!req_we_i) rsp_rdata_d = DataWidth'(w_s_thresh);
                REG_IRQEN:   if (!req_we_i) rsp_rdata_d = DataWidth'(w_s_irqen);
                REG_IRQPEND: if (!req_we_i) rsp_rdata_d = DataWidth'(w_s_pend);
                default:     rsp_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= w_accept;
            rsp_rdata_q <= w_accept ? rsp_rdata_d : '0;
            rsp_err_q   <= w_accept ? rsp_err_d : 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hemaia_multi_mailbox.sv
// ============================================================================
// tb_hemaia_multi_mailbox: directed vector table plus multi-cycle sequences.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hemaia_multi_mailbox;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [DW-1:0]   req_wdata = '0;
    logic [NCH-1:0]  hw_valid = '0;
    logic [NCH*DW-1:0] hw_data = '0;
    logic [AW-1:0]   base_addr = BASE;

    logic            req_ready, rsp_valid, rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic [NCH-1:0]  hw_ready, irq;
    logic            l_req_ready, l_rsp_valid, l_rsp_err;
    logic [DW-1:0]   l_rsp_rdata;
    logic [NCH-1:0]  l_hw_ready, l_irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Edge-triggered, active-high instance: the primary device under test.
    hemaia_multi_mailbox #(
        .NumChannels(NCH), .MailboxDepth(8), .DataWidth(DW), .AddrWidth(AW),
        .IrqEdgeTrig(1), .IrqActHigh(1)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .base_addr_i(base_addr), .hw_push_valid_i(hw_valid), .hw_push_data_i(hw_data),
        .hw_push_ready_o(hw_ready), .irq_o(irq)
    );

    // Level-triggered, active-low twin driven by identical stimulus.
    hemaia_multi_mailbox #(
        .NumChannels(NCH), .MailboxDepth(8), .DataWidth(DW), .AddrWidth(AW),
        .IrqEdgeTrig(0), .IrqActHigh(0)
    ) u_lvl (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ready_o(l_req_ready),
        .rsp_valid_o(l_rsp_valid), .rsp_rdata_o(l_rsp_rdata), .rsp_err_o(l_rsp_err),
        .base_addr_i(base_addr), .hw_push_valid_i(hw_valid), .hw_push_data_i(hw_data),
        .hw_push_ready_o(l_hw_ready), .irq_o(l_irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    function automatic logic [31:0] A(input int ch, input int r);
        return BASE + 32'(ch * 32 + r * 4);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output logic [31:0] lrdata, output logic lerr);
        int waitc;
        waitc = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        #1;
        while (!req_ready && waitc < 16) begin
            @(negedge clk); #1; waitc++;
        end
        check("bus_accept", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rsp_valid", {62'd0, rsp_valid, l_rsp_valid}, 64'd3);
        rdata = rsp_rdata; err = rsp_err; lrdata = l_rsp_rdata; lerr = l_rsp_err;
        @(negedge clk);
        check("rsp_single_cycle", {63'd0, rsp_valid}, 64'd0);
    endtask

    task automatic bus_chk(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err);
        logic [31:0] rd, lrd;
        logic        e, le;
        bus(we, addr, wdata, rd, e, lrd, le);
        check({name, "_rdata"}, {32'd0, rd}, {32'd0, exp_rdata});
        check({name, "_err"}, {63'd0, e}, {63'd0, exp_err});
    endtask

    task automatic hw_push(input int ch, input logic [31:0] d);
        int waitc;
        waitc = 0;
        @(negedge clk);
        hw_valid[ch] = 1'b1;
        hw_data[ch*DW +: DW] = d;
        #1;
        while (!hw_ready[ch] && waitc < 16) begin
            @(negedge clk); #1; waitc++;
        end
        check("hw_push_accept", {63'd0, hw_ready[ch]}, 64'd1);
        @(posedge clk); #1;
        hw_valid[ch] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; hw_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, lrd;
        logic        e, le;

        vecs[0]  = '{A(1,1), 1'b0, 32'h0,  32'h0,  1'b1};
        vecs[1]  = '{A(1,2), 1'b0, 32'h0,  32'h1,  1'b0};
        vecs[2]  = '{A(2,3), 1'b1, 32'h5,  32'h0,  1'b0};
        vecs[3]  = '{A(2,3), 1'b0, 32'h0,  32'h5,  1'b0};
        vecs[4]  = '{A(2,4), 1'b1, 32'h1,  32'h0,  1'b0};
        vecs[5]  = '{A(2,4), 1'b0, 32'h0,  32'h1,  1'b0};
        vecs[6]  = '{A(0,0), 1'b0, 32'h0,  32'h0,  1'b1};
        vecs[7]  = '{A(0,2), 1'b1, 32'h7,  32'h0,  1'b1};
        vecs[8]  = '{A(0,1), 1'b1, 32'h7,  32'h0,  1'b1};
        vecs[9]  = '{A(0,7), 1'b0, 32'h0,  32'h0,  1'b1};
        vecs[10] = '{A(4,2), 1'b0, 32'h0,  32'h0,  1'b1};
        vecs[11] = '{A(0,6), 1'b0, 32'h0,  32'h0,  1'b1};
        vecs[12] = '{BASE - 32'd4, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[13] = '{A(1,0), 1'b1, 32'h11, 32'h0,  1'b0};
        vecs[14] = '{A(1,0), 1'b1, 32'h22, 32'h0,  1'b0};
        vecs[15] = '{A(1,2), 1'b0, 32'h0,  32'h8,  1'b0};
        vecs[16] = '{A(1,1), 1'b0, 32'h0,  32'h11, 1'b0};
        vecs[17] = '{A(1,1), 1'b0, 32'h0,  32'h22, 1'b0};
        vecs[18] = '{A(1,1), 1'b0, 32'h0,  32'h0,  1'b1};
        vecs[19] = '{A(2,5), 1'b0, 32'h0,  32'h0,  1'b0};

        // Reset state, including a request presented while reset is high.
        req_valid = 1'b1; req_we = 1'b0; req_addr = A(0,2);
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", {62'd0, req_ready, l_req_ready}, 64'd0);
        check("rst_hw_ready", {56'd0, hw_ready, l_hw_ready}, 64'd0);
        check("rst_rsp", {31'd0, rsp_valid, rsp_rdata}, 64'd0);
        check("rst_irq", {56'd0, irq, l_irq}, 64'h0F);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);

        for (int i = 0; i < 20; i++) begin
            bus_chk($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Single hw push then pop on channel 2.
        hw_push(2, 32'hA5);
        bus_chk("pop_ch2", 1'b0, A(2,1), 32'h0, 32'hA5, 1'b0);
        bus_chk("status_ch2", 1'b0, A(2,2), 32'h0, 32'h1, 1'b0);

        // Overflow on channel 0, then drain in order.
        for (int i = 0; i < 8; i++) begin
            bus_chk("fill_ch0", 1'b1, A(0,0), 32'h100 + 32'(i), 32'h0, 1'b0);
        end
        bus_chk("overflow_ch0", 1'b1, A(0,0), 32'hDEAD, 32'h0, 1'b1);
        bus_chk("status_full", 1'b0, A(0,2), 32'h0, 32'h22, 1'b0);
        check("hw_ready_full", {63'd0, hw_ready[0]}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            bus_chk("drain_ch0", 1'b0, A(0,1), 32'h0, 32'h100 + 32'(i), 1'b0);
        end

        // Bus write collides with a hw push on channel 3.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = A(3,0); req_wdata = 32'hB0B;
        hw_valid[3] = 1'b1; hw_data[3*DW +: DW] = 32'hCAFE;
        #1;
        check("collide_stall", {62'd0, req_ready, hw_ready[3]}, 64'd1);
        @(posedge clk); #1;
        hw_valid[3] = 1'b0;
        @(negedge clk); #1;
        check("collide_release", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("collide_rsp", {62'd0, rsp_valid, rsp_err}, 64'd2);
        bus_chk("collide_first", 1'b0, A(3,1), 32'h0, 32'hCAFE, 1'b0);
        bus_chk("collide_second", 1'b0, A(3,1), 32'h0, 32'hB0B, 1'b0);

        // Interrupts on channel 0 from a clean state.
        do_reset();
        bus(1'b1, A(0,3), 32'h1, rd, e, lrd, le);
        bus(1'b1, A(0,4), 32'h1, rd, e, lrd, le);
        hw_push(0, 32'h1);
        hw_push(0, 32'h2);
        repeat (3) @(negedge clk);
        check("irq_raise", {56'd0, irq, l_irq}, 64'h1E);
        bus(1'b0, A(0,5), 32'h0, rd, e, lrd, le);
        check("irqpend_set", {31'd0, rd, lrd}, {31'd0, 32'd1, 32'd1});
        bus(1'b1, A(0,5), 32'h1, rd, e, lrd, le);
        check("irq_w1c", {56'd0, irq, l_irq}, 64'h0E);
        hw_push(0, 32'h3);
        repeat (3) @(negedge clk);
        check("irq_no_rearm", {56'd0, irq, l_irq}, 64'h0E);
        bus(1'b0, A(0,5), 32'h0, rd, e, lrd, le);
        check("irqpend_after", {31'd0, rd, lrd}, {31'd0, 32'd0, 32'd1});

        // Flush with a simultaneous hw push on channel 1.
        hw_push(1, 32'h55);
        hw_push(1, 32'h66);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = A(1,6); req_wdata = 32'h0;
        hw_valid[1] = 1'b1; hw_data[1*DW +: DW] = 32'h77;
        #1;
        check("flush_ready", {62'd0, req_ready, hw_ready[1]}, 64'd2);
        @(posedge clk); #1;
        req_valid = 1'b0; hw_valid[1] = 1'b0;
        @(negedge clk);
        check("flush_rsp", {62'd0, rsp_valid, rsp_err}, 64'd2);
        bus_chk("flush_status", 1'b0, A(1,2), 32'h0, 32'h1, 1'b0);
        bus_chk("ch4_write", 1'b1, A(4,3), 32'h1, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
